// File: rtl/tank_pkg.sv
// Shared types and screen constants for the tank/bullet/wall sprite fetchers.
package tank_pkg;

  localparam int unsigned SPRITE_W = 32;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb12_t;

endpackage

// File: rtl/tank_sprite_hit.sv
// Combinational sprite window test: signed offset of the scan position from the
// sprite origin, range check, and {dy,dx} ROM address pack.
module tank_sprite_hit
  import tank_pkg::*;
#(
  parameter int unsigned SPRITE_W = tank_pkg::SPRITE_W,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        sx,
  input  logic [9:0]        sy,
  input  logic              enable,
  output logic              hit,
  output logic [ADDR_W-1:0] address
);

  localparam int unsigned OFS_W = ADDR_W / 2;

  logic signed [10:0] dx;
  logic signed [10:0] dy;

  always_comb begin
    dx = signed'({1'b0, draw_x}) - signed'({1'b0, sx});
    dy = signed'({1'b0, draw_y}) - signed'({1'b0, sy});
    // All bits above the in-sprite offset (sign included) zero <=> 0 <= d < SPRITE_W,
    // so scan positions left of / above the sprite never alias into it.
    hit     = enable && (dx[10:OFS_W] == '0) && (dy[10:OFS_W] == '0);
    address = hit ? {dy[OFS_W-1:0], dx[OFS_W-1:0]} : '0;
  end

endmodule

// File: rtl/tank_sprite_fetch.sv
// Tank sprite fetch: frame-latched tank state, spawn blink, ROM address
// generation and a fixed 3-cycle pipeline to a transparency-qualified pixel.
module tank_sprite_fetch
  import tank_pkg::*;
#(
  parameter int unsigned SPRITE_W        = 32,
  parameter int unsigned ADDR_W          = 10,
  parameter logic [11:0] TRANSPARENT_RGB = 12'h000,
  parameter int unsigned BLINK_FRAMES    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        tank_x,
  input  logic [9:0]        tank_y,
  input  logic [1:0]        tank_dir,
  input  logic              tank_enemy,
  input  logic              tank_active,
  input  logic              tank_spawning,
  output logic [ADDR_W-1:0] rom_address,
  output logic              enemy,
  input  logic [11:0]       up_rgb,
  input  logic [11:0]       right_rgb,
  input  logic [11:0]       down_rgb,
  input  logic [11:0]       left_rgb,
  output logic              pixel_valid,
  output logic [11:0]       pixel_rgb
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic        shadow_active;
  logic        shadow_enemy;
  logic [9:0]  shadow_x;
  logic [9:0]  shadow_y;
  dir_t        shadow_dir;

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_hidden;

  logic              hit0;
  logic [ADDR_W-1:0] addr0;
  logic              hit_d1;
  logic              hit_d2;
  dir_t              dir_d1;
  dir_t              dir_d2;
  rgb12_t            sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_active <= 1'b0;
      shadow_enemy  <= 1'b0;
      shadow_x      <= '0;
      shadow_y      <= '0;
      shadow_dir    <= DIR_UP;
      blink_cnt     <= '0;
      blink_hidden  <= 1'b0;
    end else if (frame_start) begin
      shadow_active <= tank_active;
      shadow_enemy  <= tank_enemy;
      shadow_x      <= tank_x;
      shadow_y      <= tank_y;
      shadow_dir    <= dir_t'(tank_dir);
      if (tank_spawning) begin
        if (blink_cnt == CNT_LAST) begin
          blink_cnt    <= '0;
          blink_hidden <= ~blink_hidden;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt    <= '0;
        blink_hidden <= 1'b0;
      end
    end
  end

  tank_sprite_hit #(
    .SPRITE_W(SPRITE_W),
    .ADDR_W  (ADDR_W)
  ) u_hit (
    .draw_x (draw_x),
    .draw_y (draw_y),
    .sx     (shadow_x),
    .sy     (shadow_y),
    .enable (shadow_active && !blink_hidden),
    .hit    (hit0),
    .address(addr0)
  );

  always_comb begin
    sel = rgb12_t'(up_rgb);
    unique case (dir_d2)
      DIR_UP:    sel = rgb12_t'(up_rgb);
      DIR_RIGHT: sel = rgb12_t'(right_rgb);
      DIR_DOWN:  sel = rgb12_t'(down_rgb);
      DIR_LEFT:  sel = rgb12_t'(left_rgb);
      default:   sel = rgb12_t'(up_rgb);
    endcase
  end

  // Stage 1 drives the ROMs; stage 2 waits out the ROM read; stage 3 picks the colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_address <= '0;
      enemy       <= 1'b0;
      hit_d1      <= 1'b0;
      dir_d1      <= DIR_UP;
      hit_d2      <= 1'b0;
      dir_d2      <= DIR_UP;
      pixel_valid <= 1'b0;
      pixel_rgb   <= '0;
    end else begin
      rom_address <= addr0;
      enemy       <= shadow_enemy;
      hit_d1      <= hit0;
      dir_d1      <= shadow_dir;
      hit_d2      <= hit_d1;
      dir_d2      <= dir_d1;
      pixel_valid <= hit_d2 && (sel != rgb12_t'(TRANSPARENT_RGB));
      pixel_rgb   <= (hit_d2 && (sel != rgb12_t'(TRANSPARENT_RGB))) ? 12'(sel) : '0;
    end
  end

endmodule
